// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle,
// shift-add multiply and restoring divide, sign fix-up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | one multiply/divide iteration per cycle (WIDTH cycles)
// FIX   | apply result signs, write hi/lo, pulse done
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0]   a_orig, b_abs;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_abs_in, b_abs_in;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mult_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes; negating 0x80..0 yields 2^(WIDTH-1), exact as unsigned.
    always_comb begin
        sign_a   = op[0] & A[WIDTH-1];
        sign_b   = op[0] & B[WIDTH-1];
        a_abs_in = sign_a ? -A : A;
        b_abs_in = sign_b ? -B : B;

        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_abs} : '0);
        mult_nxt = {msum, acc[WIDTH-1:1]};

        shifted  = {rem[WIDTH-1:0], acc[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_abs};
        borrow   = diff[WIDTH+1];

        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_orig  <= '0;
            b_abs   <= '0;
            acc     <= '0;
            rem     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        b_zero  <= (B == '0);
                        a_orig  <= A;
                        b_abs   <= b_abs_in;
                        acc     <= {{WIDTH{1'b0}}, a_abs_in};
                        rem     <= '0;
                        cnt     <= CW'(WIDTH - 1);
                    end else begin
                        if (mthi_we) hi_q <= wdata;
                        if (mtlo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    // Divide keeps the dividend/quotient in the low half of acc.
                    if (is_div) begin
                        rem               <= borrow ? shifted : diff[WIDTH:0];
                        acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], ~borrow};
                    end else begin
                        acc <= mult_nxt;
                    end
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        if (b_zero) begin
                            lo_q <= '1;
                            hi_q <= a_orig;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit: results, latency,
// MTHI/MTLO arbitration, busy-time input masking and mid-operation reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] A, B, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MULTU: return {32'b0, a} * {32'b0, b};
            MULT:  return 64'(sa * sb);
            DIVU:  if (b == 0) return {a, 32'hFFFFFFFF};
                   else return {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    int          lat;
    logic [63:0] exp64;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        rst_n = 1'b0; start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op = 2'b00; A = '0; B = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        op = MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("multu_latency", lat, 33);
        check("multu_busy_at_done", {31'b0, busy}, 32'd0);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);

        run_op(MULT, 32'hFFFFFFFD, 32'h00000007, lat);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);

        // Back-to-back: started in the previous done cycle.
        run_op(DIV, 32'hFFFFFFF9, 32'h00000002, lat);
        check("div_b2b_latency", lat, 33);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(DIVU, 32'h00000064, 32'h0, lat);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'h00000064);

        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);

        run_op(DIV, 32'h00000007, 32'hFFFFFFFE, lat);
        check("div_7_m2_lo", lo, 32'hFFFFFFFD);
        check("div_7_m2_hi", hi, 32'h00000001);

        run_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check("mult_m1_m1_hi", hi, 32'h0);
        check("mult_m1_m1_lo", lo, 32'h1);

        run_op(MULTU, 32'h80000000, 32'h00000002, lat);
        check("multu_carry_hi", hi, 32'h1);
        check("multu_carry_lo", lo, 32'h0);

        run_op(DIV, 32'hFFFFFFF9, 32'h0, lat);
        check("div_zero_lo", lo, 32'hFFFFFFFF);
        check("div_zero_hi", hi, 32'hFFFFFFF9);
        @(negedge clk);

        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mt_both_hi", hi, 32'h00001234);
        check("mt_both_lo", lo, 32'h00001234);

        op = MULTU; A = 32'd2; B = 32'd3; start = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000DEAD;
        @(negedge clk);
        start = 1'b0; mtlo_we = 1'b0;
        check("start_wins_lo_held", lo, 32'h00001234);
        check("start_wins_busy", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("start_wins_hi", hi, 32'h0);
        check("start_wins_lo", lo, 32'h6);

        op = DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        op = MULTU; A = 32'd5; B = 32'd5; start = 1'b1; mthi_we = 1'b1; wdata = 32'h0000ABCD;
        @(negedge clk);
        lat++;
        start = 1'b0; mthi_we = 1'b0;
        check("busy_ignore_hi", hi, 32'h0);
        check("busy_ignore_lo", lo, 32'h6);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ignore_latency", lat, 33);
        check("divu_100_7_lo", lo, 32'h0000000E);
        check("divu_100_7_hi", hi, 32'h00000002);

        op = DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        run_op(DIVU, 32'd1000, 32'd3, lat);
        check("after_rst_latency", lat, 33);
        check("after_rst_lo", lo, 32'h0000014D);
        check("after_rst_hi", hi, 32'h00000001);

        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 17 == 0) rb = 32'h0;
            if (i % 23 == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (i % 5 == 0)  rb = 32'($urandom_range(1, 300));
            exp64 = model(rop, ra, rb);
            run_op(rop, ra, rb, lat);
            check("rand_latency", lat, 33);
            check("rand_hi", hi, exp64[63:32]);
            check("rand_lo", lo, exp64[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
